// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core support blocks: loader FSM states,
// loader error codes and program-memory constants.
package risc_pkg;

    localparam int         MEM_DEPTH  = 32;
    localparam logic [2:0] HLT_OPCODE = 3'b000;
    // Unused words are filled with a HLT instruction so a short program stops cleanly.
    localparam logic [7:0] FILL_WORD  = {HLT_OPCODE, 5'b00000};

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        FILL,
        RUN,
        DONE,
        ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_BAD_LEN = 2'b01,
        ERR_CSUM    = 2'b10
    } err_code_t;

endpackage

// File: rtl/risc_prog_loader.sv
// Program loader for the 8-bit RISC core: streams a framed image into the
// 32x8 program memory, zero-fills the tail, then runs the core until it halts.
module risc_prog_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  halt,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_run,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [2:0]            fsm_state
);
    import risc_pkg::*;

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   LAST_ADDR  = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN    = DATA_WIDTH'(MEM_DEPTH);

    loader_state_t         state;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   len;
    logic [DATA_WIDTH-1:0] csum;
    logic                  accept;
    logic                  len_ok;
    logic [DATA_WIDTH-1:0] csum_next;

    // Handshake: a byte transfers on a rising edge where in_valid & in_ready;
    // in_ready depends only on state, and in_valid outside LEN/DATA/CSUM is ignored.
    assign in_ready  = (state == LEN) || (state == DATA) || (state == CSUM);
    assign accept    = in_valid & in_ready;
    assign len_ok    = (in_data != '0) && (in_data <= MAX_LEN);
    assign csum_next = csum + in_data;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            len       <= '0;
            csum      <= '0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_run   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            mem_wr <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= LEN;
                        cnt      <= '0;
                        csum     <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                    end
                end
                LEN: begin
                    if (accept) begin
                        if (len_ok) begin
                            len   <= in_data[ADDR_WIDTH:0];
                            state <= DATA;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_LEN;
                            state    <= ERR;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem_wr    <= 1'b1;
                        mem_addr  <= cnt[ADDR_WIDTH-1:0];
                        mem_wdata <= in_data;
                        csum      <= csum_next;
                        cnt       <= cnt + 1'b1;
                        if (cnt == len - 1'b1) state <= CSUM;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (csum_next == '0) begin
                            state <= (cnt == FULL_COUNT) ? RUN : FILL;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_CSUM;
                            state    <= ERR;
                        end
                    end
                end
                FILL: begin
                    mem_wr    <= 1'b1;
                    mem_addr  <= cnt[ADDR_WIDTH-1:0];
                    mem_wdata <= FILL_WORD;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) state <= RUN;
                end
                RUN: begin
                    // The core sits in reset until cpu_run is high, so halt is only trusted after that.
                    cpu_run <= 1'b1;
                    if (cpu_run && halt) begin
                        cpu_run <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
